fab_clk_supervisor: RTL

Fabric-side consumer of the MSS CCC clock outputs. Runs on `FAB_CLK`, qualifies the CCC lock indication and sequences a clean fabric reset release once the clock is stable. Also measures `FAB_CLK` frequency against a slow reference tick and flags out-of-range periods. Sits between the CCC wrapper and every fabric block that needs `FAB_RESET_N`.

---
 rtl/fab_clk_supervisor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fab_clk_supervisor.sv
// Fabric clock supervisor: qualifies CCC lock, sequences FAB_RESET_N release, measures FAB_CLK against REF_TICK.
// Optional build macro CCC_LOCK_BYPASS_EN: lock input ignored, lock treated as always qualified.
//
// state     | meaning
// WAIT_LOCK | fabric held in reset, waiting for synchronized lock
// STABLE    | lock seen, counting LOCK_HOLD consecutive locked cycles
// RELEASE   | lock qualified, reset held RST_HOLD more cycles
// RUN       | fabric reset released, READY high
module fab_clk_supervisor #(
    parameter int LOCK_HOLD = 1024,
    parameter int RST_HOLD  = 16,
    parameter int CNT_W     = 16,
    parameter int FREQ_MIN  = 2900,
    parameter int FREQ_MAX  = 3200
) (
    input  logic             FAB_CLK,
    input  logic             M2F_RESET_N,
    input  logic             FAB_LOCK,
    input  logic             REF_TICK,
    input  logic             CLR_FAULT,
    output logic             FAB_RESET_N,
    output logic             READY,
    output logic [1:0]       STATE,
    output logic [7:0]       LOSS_CNT,
    output logic [CNT_W-1:0] FREQ_COUNT,
    output logic             FREQ_VALID,
    output logic             FREQ_OK,
    output logic             FREQ_FAULT
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int HOLD_MAX = (LOCK_HOLD > RST_HOLD) ? LOCK_HOLD : RST_HOLD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] LOCK_LAST = HOLD_W'(LOCK_HOLD - 1);
    localparam logic [HOLD_W-1:0] RST_LAST  = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_ALL   = '1;
    localparam logic [CNT_W-1:0]  F_MIN     = CNT_W'(FREQ_MIN);
    localparam logic [CNT_W-1:0]  F_MAX     = CNT_W'(FREQ_MAX);

    state_t            state, state_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [7:0]        loss_nx;
    logic              lock_s;
    logic              tick_meta, tick_s, tick_d, tick_rise;
    logic              armed, timed_out;
    logic [CNT_W-1:0]  win_cnt, meas;

`ifdef CCC_LOCK_BYPASS_EN
    // CCC in bypass ties lock low, so the lock pin carries no information.
    logic unused_lock;
    assign unused_lock = FAB_LOCK;
    assign lock_s      = 1'b1;
`else
    logic lock_meta;

    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= FAB_LOCK;
            lock_s    <= lock_meta;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        loss_nx  = LOSS_CNT;
        unique case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = STABLE;
                    hold_nx  = '0;
                end
            end
            STABLE: begin
                hold_nx = hold_cnt + 1'b1;
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                end else if (hold_cnt == LOCK_LAST) begin
                    state_nx = RELEASE;
                    hold_nx  = '0;
                end
            end
            RELEASE: begin
                hold_nx = hold_cnt + 1'b1;
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                end else if (hold_cnt == RST_LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    if (LOSS_CNT != 8'hFF) loss_nx = LOSS_CNT + 8'd1;
                end
            end
            default: state_nx = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            state       <= WAIT_LOCK;
            hold_cnt    <= '0;
            LOSS_CNT    <= '0;
            FAB_RESET_N <= 1'b0;
            READY       <= 1'b0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_nx;
            LOSS_CNT    <= loss_nx;
            FAB_RESET_N <= (state_nx == RUN);
            READY       <= (state_nx == RUN);
        end
    end

    assign STATE     = state;
    assign tick_rise = tick_s & ~tick_d;
    assign meas      = (win_cnt == CNT_ALL) ? CNT_ALL : win_cnt + 1'b1;

    // Window starts at 0 on the edge, so the period is the count plus the edge cycle itself.
    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            tick_meta  <= 1'b0;
            tick_s     <= 1'b0;
            tick_d     <= 1'b0;
            armed      <= 1'b0;
            timed_out  <= 1'b0;
            win_cnt    <= '0;
            FREQ_COUNT <= '0;
            FREQ_VALID <= 1'b0;
            FREQ_OK    <= 1'b0;
            FREQ_FAULT <= 1'b0;
        end else begin
            tick_meta  <= REF_TICK;
            tick_s     <= tick_meta;
            tick_d     <= tick_s;
            FREQ_VALID <= 1'b0;
            if (tick_rise) begin
                win_cnt   <= '0;
                armed     <= 1'b1;
                timed_out <= 1'b0;
                if (armed) begin
                    FREQ_COUNT <= meas;
                    FREQ_OK    <= (meas >= F_MIN) && (meas <= F_MAX);
                    FREQ_VALID <= 1'b1;
                end
            end else if (win_cnt != CNT_ALL) begin
                win_cnt <= win_cnt + 1'b1;
            end else if (armed && !timed_out) begin
                timed_out  <= 1'b1;
                FREQ_COUNT <= CNT_ALL;
                FREQ_OK    <= 1'b0;
                FREQ_VALID <= 1'b1;
            end
            if (FREQ_VALID && !FREQ_OK && (state == RUN)) begin
                FREQ_FAULT <= 1'b1;
            end else if (CLR_FAULT) begin
                FREQ_FAULT <= 1'b0;
            end
        end
    end

endmodule
